stopwatch_bcd: RTL and testbench

Stopwatch core sitting directly downstream of the board clock divider. It consumes the divider's slow toggling clock as a sampled data input in the `clkin` domain and counts one centisecond per `TICK_DIV` rising edges. It keeps minutes, seconds and centiseconds in packed BCD for the seven-segment driver. Start/stop, clear and (optionally) lap are controlled by pre-debounced buttons.

---
 rtl/stopwatch_bcd_if.sv | 24 ++
 rtl/stopwatch_bcd.sv | 196 +++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_bcd_if.sv
// Button/tick inputs and BCD display outputs of the stopwatch core.
// master = control/display side, slave = stopwatch_bcd.
interface stopwatch_bcd_if;
    logic       tick_in;
    logic       btn_ss;
    logic       btn_clr;
    logic       btn_lap;
    logic       running;
    logic       lap_active;
    logic       ovf;
    logic [7:0] disp_cs;
    logic [7:0] disp_sec;
    logic [7:0] disp_min;

    modport master (
        output tick_in, btn_ss, btn_clr, btn_lap,
        input  running, lap_active, ovf, disp_cs, disp_sec, disp_min
    );

    modport slave (
        input  tick_in, btn_ss, btn_clr, btn_lap,
        output running, lap_active, ovf, disp_cs, disp_sec, disp_min
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch (mm:ss.cc) counting rising edges of a divided clock sampled on clkin.
// Define STOPWATCH_LAP_EN to build the LAP state with a frozen lap display.
module stopwatch_bcd #(
    parameter int TICK_DIV = 1,
    parameter int MAX_MIN  = 99
) (
    input logic            clkin,
    input logic            rst,
    stopwatch_bcd_if.slave sw
);
    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  MIN_LAST = 8'((MAX_MIN / 10) * 16 + (MAX_MIN % 10));

    typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

`ifdef STOPWATCH_LAP_EN
    localparam int NIN = 4;
`else
    localparam int NIN = 3;
`endif

    logic [NIN-1:0] in_vec;
    logic [NIN-1:0] in_q_reg;
    logic [NIN-1:0] edge_vec;

`ifdef STOPWATCH_LAP_EN
    assign in_vec = {sw.btn_lap, sw.btn_clr, sw.btn_ss, sw.tick_in};
`else
    assign in_vec = {sw.btn_clr, sw.btn_ss, sw.tick_in};
`endif

    // Sampled in and out of reset alike, so an input held high across reset gives no edge.
    always_ff @(posedge clkin) begin
        in_q_reg <= in_vec;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_edge
            assign edge_vec[gi] = in_vec[gi] & ~in_q_reg[gi];
        end
    endgenerate

    logic tick_edge, ss_edge, clr_edge;
    assign tick_edge = edge_vec[0];
    assign ss_edge   = edge_vec[1];
    assign clr_edge  = edge_vec[2];

    state_t      state_reg;
    logic [7:0]  cs_reg, sec_reg, min_reg;
    logic [15:0] pre_reg;
    logic        ovf_reg, running_reg;
    logic        counting, pre_bump, advance;

    assign counting = (state_reg == RUN) || (state_reg == LAP);
    assign pre_bump = tick_edge && counting;
    assign advance  = pre_bump && (pre_reg == PRE_LAST);

    logic [7:0] cs_next, sec_next, min_next;
    logic       wrap_next;

    // One-centisecond BCD increment of the whole chain.
    always_comb begin
        cs_next   = cs_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        wrap_next = 1'b0;
        if (cs_reg[3:0] != 4'd9) begin
            cs_next[3:0] = cs_reg[3:0] + 4'd1;
        end else if (cs_reg[7:4] != 4'd9) begin
            cs_next = {cs_reg[7:4] + 4'd1, 4'd0};
        end else begin
            cs_next = 8'h00;
            if (sec_reg[3:0] != 4'd9) begin
                sec_next[3:0] = sec_reg[3:0] + 4'd1;
            end else if (sec_reg[7:4] != 4'd5) begin
                sec_next = {sec_reg[7:4] + 4'd1, 4'd0};
            end else begin
                sec_next = 8'h00;
                if (min_reg == MIN_LAST) begin
                    min_next  = 8'h00;
                    wrap_next = 1'b1;
                end else if (min_reg[3:0] != 4'd9) begin
                    min_next[3:0] = min_reg[3:0] + 4'd1;
                end else begin
                    min_next = {min_reg[7:4] + 4'd1, 4'd0};
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_edge;
    logic       lap_active_reg;
    logic [7:0] lap_cs_reg, lap_sec_reg, lap_min_reg;
    assign lap_edge = edge_vec[3];
`endif

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_reg   <= IDLE;
            cs_reg      <= 8'h00;
            sec_reg     <= 8'h00;
            min_reg     <= 8'h00;
            pre_reg     <= 16'd0;
            ovf_reg     <= 1'b0;
            running_reg <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_active_reg <= 1'b0;
            lap_cs_reg     <= 8'h00;
            lap_sec_reg    <= 8'h00;
            lap_min_reg    <= 8'h00;
`endif
        end else begin
            // Ticks act on the current state, independent of any transition this cycle.
            if (pre_bump) begin
                if (advance) begin
                    pre_reg <= 16'd0;
                    cs_reg  <= cs_next;
                    sec_reg <= sec_next;
                    min_reg <= min_next;
                    if (wrap_next) ovf_reg <= 1'b1;
                end else begin
                    pre_reg <= pre_reg + 16'd1;
                end
            end
            case (state_reg)
                IDLE: begin
                    if (ss_edge) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (ss_edge) begin
                        state_reg   <= STOP;
                        running_reg <= 1'b0;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (lap_edge) begin
                        state_reg      <= LAP;
                        lap_active_reg <= 1'b1;
                        lap_cs_reg     <= cs_reg;
                        lap_sec_reg    <= sec_reg;
                        lap_min_reg    <= min_reg;
                    end
`endif
                end
                STOP: begin
                    if (clr_edge) begin
                        state_reg <= IDLE;
                        cs_reg    <= 8'h00;
                        sec_reg   <= 8'h00;
                        min_reg   <= 8'h00;
                        pre_reg   <= 16'd0;
                        ovf_reg   <= 1'b0;
                    end else if (ss_edge) begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
`ifdef STOPWATCH_LAP_EN
                LAP: begin
                    if (ss_edge) begin
                        state_reg      <= STOP;
                        running_reg    <= 1'b0;
                        lap_active_reg <= 1'b0;
                    end else if (lap_edge) begin
                        state_reg      <= RUN;
                        lap_active_reg <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_reg   <= IDLE;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sw.running = running_reg;
    assign sw.ovf     = ovf_reg;

`ifdef STOPWATCH_LAP_EN
    assign sw.lap_active = lap_active_reg;
    assign sw.disp_cs    = lap_active_reg ? lap_cs_reg  : cs_reg;
    assign sw.disp_sec   = lap_active_reg ? lap_sec_reg : sec_reg;
    assign sw.disp_min   = lap_active_reg ? lap_min_reg : min_reg;
`else
    assign sw.lap_active = 1'b0;
    assign sw.disp_cs    = cs_reg;
    assign sw.disp_sec   = sec_reg;
    assign sw.disp_min   = min_reg;
`endif
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench: dut_a (TICK_DIV=1, MAX_MIN=1) for the main behaviour, dut_b (TICK_DIV=4) for the prescaler.
// Expected values come from a centisecond-total model; works with or without STOPWATCH_LAP_EN.
module tb_stopwatch_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_bcd_if ifa ();
    stopwatch_bcd_if ifb ();

    stopwatch_bcd #(.TICK_DIV(1), .MAX_MIN(1)) dut_a (.clkin(clk), .rst(rst), .sw(ifa));
    stopwatch_bcd #(.TICK_DIV(4), .MAX_MIN(99)) dut_b (.clkin(clk), .rst(rst), .sw(ifb));

    typedef enum {M_IDLE, M_RUN, M_STOP, M_LAP} mstate_t;
    typedef struct {
        string       tag;
        logic [26:0] v;
    } exp_t;

    localparam int WRAP_A = 12000;   // (MAX_MIN+1) minutes of centiseconds

    exp_t    sb_q[$];
    int      n_assert = 0;
    int      n_fail   = 0;
    mstate_t m_st     = M_IDLE;
    int      total    = 0;
    int      snap     = 0;
    bit      m_ovf    = 1'b0;
    int      b_edges  = 0;
    bit      b_run    = 1'b0;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [26:0] model_a();
        int  d;
        bit  run;
        d   = (m_st == M_LAP) ? snap : total;
        run = (m_st == M_RUN) || (m_st == M_LAP);
        return {bcd(d / 6000), bcd((d / 100) % 60), bcd(d % 100), run, m_st == M_LAP, m_ovf};
    endfunction

    function automatic logic [26:0] model_b();
        int d;
        d = b_edges / 4;
        return {bcd(d / 6000), bcd((d / 100) % 60), bcd(d % 100), b_run, 1'b0, 1'b0};
    endfunction

    function automatic logic [26:0] obs_a();
        return {ifa.disp_min, ifa.disp_sec, ifa.disp_cs, ifa.running, ifa.lap_active, ifa.ovf};
    endfunction

    function automatic logic [26:0] obs_b();
        return {ifb.disp_min, ifb.disp_sec, ifb.disp_cs, ifb.running, ifb.lap_active, ifb.ovf};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [26:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [26:0] obs);
        exp_t e;
        e = sb_q.pop_front();
        n_assert++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed min/sec/cs/run/lap/ovf=%h required=%h", e.tag, obs, e.v);
        end
        $display("check %-20s observed=%h expected=%h", e.tag, obs, e.v);
    endtask

    // One cycle of input events on dut_a, then a quiet cycle so the next event is a fresh edge.
    task automatic ev_a(input bit t, input bit s, input bit c, input bit l, input string tag);
        bit cnt;
        ifa.tick_in = t;
        ifa.btn_ss  = s;
        ifa.btn_clr = c;
        ifa.btn_lap = l;
        cnt = (m_st == M_RUN) || (m_st == M_LAP);
        case (m_st)
            M_IDLE: if (s) m_st = M_RUN;
            M_RUN: begin
                if (s) m_st = M_STOP;
`ifdef STOPWATCH_LAP_EN
                else if (l) begin
                    snap = total;
                    m_st = M_LAP;
                end
`endif
            end
            M_STOP: begin
                if (c) begin
                    m_st  = M_IDLE;
                    total = 0;
                    m_ovf = 1'b0;
                end else if (s) m_st = M_RUN;
            end
            M_LAP: begin
                if (s) m_st = M_STOP;
                else if (l) m_st = M_RUN;
            end
            default: m_st = M_IDLE;
        endcase
        if (t && cnt) begin
            total++;
            if (total == WRAP_A) begin
                total = 0;
                m_ovf = 1'b1;
            end
        end
        if (tag != "") push(tag, model_a());
        step();
        if (tag != "") sb_check(obs_a());
        ifa.tick_in = 1'b0;
        ifa.btn_ss  = 1'b0;
        ifa.btn_clr = 1'b0;
        ifa.btn_lap = 1'b0;
        step();
    endtask

    task automatic ticks_a(input int n, input string tag);
        for (int i = 0; i < n - 1; i++) ev_a(1'b1, 1'b0, 1'b0, 1'b0, "");
        ev_a(1'b1, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic ev_b(input bit t, input bit s, input string tag);
        bit cnt;
        cnt = b_run;
        ifb.tick_in = t;
        ifb.btn_ss  = s;
        if (s) b_run = !b_run;
        if (t && cnt) b_edges++;
        if (tag != "") push(tag, model_b());
        step();
        if (tag != "") sb_check(obs_b());
        ifb.tick_in = 1'b0;
        ifb.btn_ss  = 1'b0;
        step();
    endtask

    task automatic ticks_b(input int n, input string tag);
        for (int i = 0; i < n - 1; i++) ev_b(1'b1, 1'b0, "");
        ev_b(1'b1, 1'b0, tag);
    endtask

    initial begin
        ifa.tick_in = 1'b0; ifa.btn_ss = 1'b1; ifa.btn_clr = 1'b0; ifa.btn_lap = 1'b0;
        ifb.tick_in = 1'b0; ifb.btn_ss = 1'b0; ifb.btn_clr = 1'b0; ifb.btn_lap = 1'b0;

        // Reset with start/stop held high: releasing it must not start the watch.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        push("reset_hold", model_a());
        step();
        step();
        sb_check(obs_a());
        ifa.btn_ss = 1'b0;
        step();

        ev_a(0, 1, 0, 0, "start");
        ticks_a(150, "run_150");
        ev_a(0, 1, 0, 0, "stop");
        ticks_a(20, "stop_hold_20");
        ev_a(0, 1, 0, 0, "restart");
        ev_a(0, 0, 1, 0, "clr_in_run");
        ticks_a(5, "run_after_clr");

        ticks_a(5844, "at_00_59_99");
        ticks_a(1, "min_carry");
        ticks_a(5999, "at_01_59_99");
        ticks_a(1, "wrap_ovf");
        ticks_a(3, "post_wrap");
        ev_a(0, 1, 0, 0, "stop_after_wrap");
        ev_a(0, 0, 1, 0, "clr_in_stop");

        ev_a(0, 1, 0, 0, "run3");
        ticks_a(7, "");
        ev_a(0, 1, 0, 0, "stop3");
        ev_a(0, 1, 1, 0, "ss_clr_same");

        ev_a(0, 1, 0, 0, "");
        ticks_a(10, "");
        ev_a(0, 1, 0, 0, "");
        ev_a(1, 1, 0, 0, "tick_ss_from_stop");
        ev_a(1, 1, 0, 0, "tick_ss_from_run");

        // Lap: enter on the same cycle as a tick to check the capture is pre-update.
        ev_a(0, 1, 1, 0, "");
        ev_a(0, 1, 0, 0, "");
        ticks_a(200, "lap_at_02_00");
        ev_a(1, 0, 0, 1, "lap_enter");
        ticks_a(299, "lap_hold");
        ev_a(0, 0, 0, 1, "lap_exit");

        // Synchronous reset mid-count.
        ticks_a(4, "");
        rst = 1'b1;
        m_st  = M_IDLE;
        total = 0;
        m_ovf = 1'b0;
        push("rst_mid", model_a());
        step();
        sb_check(obs_a());
        rst = 1'b0;
        b_edges = 0;
        b_run   = 1'b0;
        step();

        // Prescaler instance.
        ev_b(0, 1, "b_start");
        ticks_b(40, "b_40_edges");
        ev_b(0, 1, "b_stop");
        ev_b(1, 1, "b_tick_ss_stop");
        ticks_b(3, "b_3_more");
        ticks_b(1, "b_advance");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
